cr_huf_comp_stcl_unpacker: RTL and testbench

Receive-side counterpart of the small-table codelength (STCL) header packer. The block accepts packed header words in the same bit layout the compressor writes, and unpacks them LSB-first. In deflate mode it decodes 3-bit fields in the deflate permutation order; otherwise it decodes delta codes. It rebuilds the per-symbol codelength array and pulses done when the array is complete. It sits in the Huffman header-parse path, ahead of the small-table code generator.

---
 rtl/cr_huf_comp_stcl_unpacker.sv | 213 +++++++++++++++++++++
 tb/tb_cr_huf_comp_stcl_unpacker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_stcl_unpacker.sv
// STCL header unpacker: consumes packed header words LSB-first and rebuilds the per-symbol
// codelength array. Define CR_HUF_COMP_STCL_UNPACK_CHK_EN to add the sticky size_err check.
module cr_huf_comp_stcl_unpacker #(
   parameter int unsigned MAX_NUM_SYM_USED = 33,
   parameter int unsigned CODELENGTH_WIDTH = 4,
   parameter int unsigned HDR_WIDTH        = 64,
   parameter int unsigned SIZE_WIDTH       = 8
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         start,
   input  logic                                         deflate_mode,
   input  logic [SIZE_WIDTH-1:0]                        stcl_size,
   input  logic [3:0]                                   hclen,
   input  logic                                         in_valid,
   input  logic [HDR_WIDTH-1:0]                         in_data,
   output logic                                         in_ready,
   output logic [MAX_NUM_SYM_USED*CODELENGTH_WIDTH-1:0] sym_dpth,
   output logic                                         done,
   output logic                                         busy
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
   ,
   output logic                                         size_err
`endif
);

   localparam int unsigned BUF_W   = 2 * HDR_WIDTH;
   localparam int unsigned AVAIL_W = $clog2(BUF_W + 1);
   localparam int unsigned CNT_W   = SIZE_WIDTH + 2;
   localparam int unsigned IDX_W   = $clog2(MAX_NUM_SYM_USED + 20);
   localparam int unsigned DPTH_W  = MAX_NUM_SYM_USED * CODELENGTH_WIDTH;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                      state_q;
   logic                        mode_q;
   logic [SIZE_WIDTH-1:0]       size_q;
   logic [3:0]                  hclen_q;
   logic [SIZE_WIDTH-1:0]       words_need_q;
   logic [SIZE_WIDTH-1:0]       words_taken_q;
   logic [BUF_W-1:0]            buf_q;
   logic [AVAIL_W-1:0]          avail_q;
   logic [CNT_W-1:0]            consumed_q;
   logic [IDX_W-1:0]            k_q;
   logic [CODELENGTH_WIDTH-1:0] prev_q;
   logic [DPTH_W-1:0]           sym_dpth_q;
   logic                        done_q;
   logic                        size_err_q;

   logic [31:0]                 avail32, cons32, size32, target, remaining, need;
   logic [31:0]                 sh, wr_idx, avail_after, avail_d, cons_d;
   logic                        run, more, have_bits, fire, last, overrun, stop, accept;
   logic [CODELENGTH_WIDTH-1:0] cl, x_ext;
   logic [BUF_W-1:0]            buf_d;

   // Deflate codelength-code permutation order.
   function automatic logic [31:0] defl_seq(input logic [31:0] k);
      case (k)
         32'd0:   defl_seq = 32'd16;
         32'd1:   defl_seq = 32'd17;
         32'd2:   defl_seq = 32'd18;
         32'd3:   defl_seq = 32'd0;
         32'd4:   defl_seq = 32'd8;
         32'd5:   defl_seq = 32'd7;
         32'd6:   defl_seq = 32'd9;
         32'd7:   defl_seq = 32'd6;
         32'd8:   defl_seq = 32'd10;
         32'd9:   defl_seq = 32'd5;
         32'd10:  defl_seq = 32'd11;
         32'd11:  defl_seq = 32'd4;
         32'd12:  defl_seq = 32'd12;
         32'd13:  defl_seq = 32'd3;
         32'd14:  defl_seq = 32'd13;
         32'd15:  defl_seq = 32'd2;
         32'd16:  defl_seq = 32'd14;
         32'd17:  defl_seq = 32'd1;
         32'd18:  defl_seq = 32'd15;
         default: defl_seq = 32'd0;
      endcase
   endfunction

   always_comb begin
      avail32   = 32'(avail_q);
      cons32    = 32'(consumed_q);
      size32    = 32'(size_q);
      run       = (state_q == StRun);
      target    = mode_q ? 32'(hclen_q) + 32'd4 : MAX_NUM_SYM_USED;
      more      = 32'(k_q) < target;
      have_bits = cons32 < size32;
      remaining = size32 - cons32;
      need      = (remaining < 32'd4) ? remaining : 32'd4;
      fire      = run && more && have_bits && (avail32 >= need);
      last      = fire && (32'(k_q) + 32'd1 == target);
      overrun   = run && more && !have_bits;
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
      stop      = overrun;
`else
      // Without the check only an empty header may finish early; other overruns hang.
      stop      = overrun && (size32 == 32'd0);
`endif
      in_ready  = run && (avail32 <= HDR_WIDTH) && (words_taken_q < words_need_q);
      accept    = in_ready && in_valid;

      x_ext = CODELENGTH_WIDTH'(buf_q[3:1]);
      if (mode_q) begin
         sh     = 32'd3;
         cl     = CODELENGTH_WIDTH'(buf_q[2:0]);
         wr_idx = defl_seq(32'(k_q));
      end else begin
         wr_idx = 32'(k_q);
         if (!buf_q[0]) begin
            sh = 32'd1;
            cl = prev_q;
         end else begin
            sh = 32'd4;
            cl = (x_ext >= prev_q) ? x_ext + CODELENGTH_WIDTH'(1) : x_ext;
         end
      end

      // Decode uses the pre-accept buffer; a new word lands above whatever survives the shift.
      buf_d       = buf_q;
      avail_after = avail32;
      if (fire) begin
         buf_d       = buf_q >> sh;
         avail_after = (avail32 >= sh) ? avail32 - sh : 32'd0;
      end
      avail_d = avail_after;
      if (accept) begin
         buf_d   = buf_d | (BUF_W'(in_data) << avail_after);
         avail_d = avail_after + HDR_WIDTH;
      end
      cons_d = fire ? cons32 + sh : cons32;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         mode_q        <= 1'b0;
         size_q        <= '0;
         hclen_q       <= '0;
         words_need_q  <= '0;
         words_taken_q <= '0;
         buf_q         <= '0;
         avail_q       <= '0;
         consumed_q    <= '0;
         k_q           <= '0;
         prev_q        <= CODELENGTH_WIDTH'(4);
         sym_dpth_q    <= '0;
         done_q        <= 1'b0;
         size_err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q       <= StRun;
                  mode_q        <= deflate_mode;
                  size_q        <= stcl_size;
                  hclen_q       <= hclen;
                  words_need_q  <= SIZE_WIDTH'((32'(stcl_size) + HDR_WIDTH - 1) / HDR_WIDTH);
                  words_taken_q <= '0;
                  buf_q         <= '0;
                  avail_q       <= '0;
                  consumed_q    <= '0;
                  k_q           <= '0;
                  prev_q        <= CODELENGTH_WIDTH'(4);
                  sym_dpth_q    <= '0;
                  size_err_q    <= 1'b0;
               end
            end
            StRun: begin
               buf_q      <= buf_d;
               avail_q    <= AVAIL_W'(avail_d);
               consumed_q <= CNT_W'(cons_d);
               if (accept) words_taken_q <= words_taken_q + 1'b1;
               if (fire) begin
                  k_q <= k_q + 1'b1;
                  if (!mode_q) prev_q <= cl;
                  for (int i = 0; i < int'(MAX_NUM_SYM_USED); i++) begin
                     if (wr_idx == 32'(i)) begin
                        sym_dpth_q[i*CODELENGTH_WIDTH +: CODELENGTH_WIDTH] <= cl;
                     end
                  end
               end
               if (last || stop) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
               if (overrun) size_err_q <= 1'b1;
               if (last && ((cons_d != size32) ||
                            (mode_q && (size32 != 32'd3 * (32'(hclen_q) + 32'd4))))) begin
                  size_err_q <= 1'b1;
               end
`endif
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sym_dpth = sym_dpth_q;
   assign done     = done_q;
   assign busy     = (state_q != StIdle);
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
   assign size_err = size_err_q;
`else
   logic unused_err;
   assign unused_err = size_err_q;
`endif

endmodule

// File: tb/tb_cr_huf_comp_stcl_unpacker.sv
// Scoreboard bench for cr_huf_comp_stcl_unpacker: directed header cases plus randomized
// headers checked against a behavioural decode model.
module tb_cr_huf_comp_stcl_unpacker;

   localparam int NSYM = 33;
   localparam int CW   = 4;
   localparam int HW   = 64;
   localparam int DW   = NSYM * CW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          deflate_mode = 1'b0;
   logic [7:0]    stcl_size = '0;
   logic [3:0]    hclen = '0;
   logic          in_valid = 1'b0;
   logic [HW-1:0] in_data = '0;
   logic          in_ready, done, busy;
   logic [DW-1:0] sym_dpth;
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
   logic          size_err;
`endif

   cr_huf_comp_stcl_unpacker dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .deflate_mode (deflate_mode),
      .stcl_size    (stcl_size),
      .hclen        (hclen),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .sym_dpth     (sym_dpth),
      .done         (done),
      .busy         (busy)
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
      ,
      .size_err     (size_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] dpth;
      logic          err;
      int            start;
      int            lat;
   } exp_t;

   exp_t          sb[$];
   int            n_chk = 0;
   int            n_fail = 0;
   logic [HW-1:0] words [4];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] ent(input int i);
      return sym_dpth[i*CW +: CW];
   endfunction

   // Walks the header bit string symbol by symbol using the decode rules directly.
   function automatic void ref_model(input logic mode, input int size, input int hc,
                                     output logic [DW-1:0] dp, output logic err,
                                     output bit over, output int n, output int cons);
      int            seq [19] = '{16, 17, 18, 0, 8, 7, 9, 6, 10, 5, 11, 4, 12, 3, 13, 2, 14, 1, 15};
      logic [255:0]  stream;
      int            nw, target, prev, x, c;
      nw     = (size + HW - 1) / HW;
      stream = '0;
      for (int i = 0; i < nw && i < 4; i++) stream[i*HW +: HW] = words[i];
      dp     = '0;
      prev   = 4;
      cons   = 0;
      n      = 0;
      over   = 1'b0;
      target = mode ? hc + 4 : NSYM;
      for (int k = 0; k < target; k++) begin
         if (cons >= size) begin
            over = 1'b1;
            break;
         end
         if (mode) begin
            dp[seq[k]*CW +: CW] = CW'(stream[cons +: 3]);
            cons += 3;
         end else if (stream[cons] == 1'b0) begin
            dp[k*CW +: CW] = CW'(prev);
            cons += 1;
         end else begin
            x = int'(stream[cons+1 +: 3]);
            c = (x >= prev) ? x + 1 : x;
            dp[k*CW +: CW] = CW'(c);
            prev = c;
            cons += 4;
         end
         n++;
      end
      err = over || (cons != size) || (mode && (size != 3 * (hc + 4)));
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // vpat: 0 = in_valid held high, 1 = random, 2 = alternating 1/0.
   task automatic run_txn(input logic mode, input int size, input int hc, input int vpat);
      exp_t e;
      bit   over;
      int   n, cons, widx, acc, to;
      ref_model(mode, size, hc, e.dpth, e.err, over, n, cons);
      if (size == 0) e.lat = 2;
      else if (vpat == 0 && !over) e.lat = n + 2;
      else e.lat = -1;
      @(negedge clk);
      start        = 1'b1;
      deflate_mode = mode;
      stcl_size    = 8'(size);
      hclen        = 4'(hc);
      e.start      = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
      chk("size_err_cleared_on_start", {131'd0, size_err}, '0);
`endif
      widx = 0;
      acc  = 0;
      for (to = 0; to < 500; to++) begin
         if (done) break;
         in_valid = (vpat == 0) ? 1'b1 : (vpat == 2) ? ~to[0] : ($urandom_range(0, 2) != 0);
         in_data  = (widx < 4) ? words[widx] : '0;
         if (in_valid && in_ready) begin
            widx++;
            acc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (to >= 500) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: no done within 500 cycles (size %0d mode %0d)", size, mode);
         do_reset();
         sb.delete();
      end
      chk("words_requested_bound", DW'(acc <= (size + HW - 1) / HW), DW'(1));
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         chk("in_ready_only_when_busy", DW'(in_ready & ~busy), '0);
         if (done) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: done=1, expected no pending transaction");
            end else begin
               e = sb.pop_front();
               chk("sym_dpth", sym_dpth, e.dpth);
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
               chk("size_err", DW'(size_err), DW'(e.err));
`endif
               if (e.lat >= 0) chk("done_latency", DW'(cyc - e.start), DW'(e.lat));
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] dp;
      logic          err;
      bit            over;
      int            n, c, size, mode, hc, pick, sty;

      repeat (3) @(negedge clk);
      chk("reset_in_ready", DW'(in_ready), '0);
      chk("reset_done", DW'(done), '0);
      chk("reset_busy", DW'(busy), '0);
      chk("reset_sym_dpth", sym_dpth, '0);
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
      chk("reset_size_err", DW'(size_err), '0);
`endif
      rst_n = 1'b1;

      // Deflate, hclen=0.
      words = '{64'hB1A, 64'h0, 64'h0, 64'h0};
      run_txn(1'b1, 12, 0, 0);
      chk("defl_16", DW'(ent(16)), DW'(2));
      chk("defl_17", DW'(ent(17)), DW'(3));
      chk("defl_18", DW'(ent(18)), DW'(4));
      chk("defl_0", DW'(ent(0)), DW'(5));
      chk("defl_1", DW'(ent(1)), DW'(0));

      // Non-deflate, all zeros.
      words = '{64'h0, 64'h0, 64'h0, 64'h0};
      run_txn(1'b0, 33, 0, 0);
      for (int i = 0; i < NSYM; i += 8) chk("zeros_entry", DW'(ent(i)), DW'(4));

      // Non-deflate delta.
      words = '{64'hF2, 64'h0, 64'h0, 64'h0};
      run_txn(1'b0, 39, 0, 0);
      chk("delta_0", DW'(ent(0)), DW'(4));
      chk("delta_1", DW'(ent(1)), DW'(5));
      chk("delta_2", DW'(ent(2)), DW'(3));
      chk("delta_32", DW'(ent(32)), DW'(3));

      // Multi-word, all ones, in_valid alternating.
      words = '{'1, '1, '1, '1};
      run_txn(1'b0, 132, 0, 2);
      chk("multi_0", DW'(ent(0)), DW'(8));
      chk("multi_1", DW'(ent(1)), DW'(7));
      chk("multi_32", DW'(ent(32)), DW'(8));

      // Empty header.
      run_txn(1'b0, 0, 0, 0);

`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
      words = '{64'h5A5, 64'h0, 64'h0, 64'h0};
      run_txn(1'b1, 12, 1, 0);
      chk("chk_size_err_set", DW'(size_err), DW'(1));
      words = '{64'hB1A, 64'h0, 64'h0, 64'h0};
      run_txn(1'b1, 12, 0, 0);
      chk("chk_size_err_clear", DW'(size_err), DW'(0));
`endif

      // Reset in the middle of a run.
      words = '{64'hF2, 64'h0, 64'h0, 64'h0};
      @(negedge clk);
      start = 1'b1; deflate_mode = 1'b0; stcl_size = 8'd39; hclen = 4'd0;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = words[0];
      for (int t = 0; t < 10 && !in_ready; t++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", DW'(in_ready), '0);
      chk("midrst_done", DW'(done), '0);
      chk("midrst_busy", DW'(busy), '0);
      chk("midrst_sym_dpth", sym_dpth, '0);
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
      chk("midrst_size_err", DW'(size_err), '0);
`endif
      rst_n = 1'b1;
      run_txn(1'b0, 39, 0, 0);
      chk("after_rst_1", DW'(ent(1)), DW'(5));

      // Randomized headers.
      for (int t = 0; t < 40; t++) begin
         mode = int'($urandom_range(0, 1));
         hc   = int'($urandom_range(0, 15));
         for (int w = 0; w < 4; w++) begin
            sty = int'($urandom_range(0, 2));
            if (sty == 0) words[w] = {$urandom, $urandom};
            else if (sty == 1) words[w] = {$urandom, $urandom} & {$urandom, $urandom};
            else words[w] = {$urandom, $urandom} | {$urandom, $urandom};
         end
         ref_model(mode[0], 255, hc, dp, err, over, n, c);
         pick = int'($urandom_range(0, 3));
         size = c;
         if (pick == 2) size = c + int'($urandom_range(0, 7));
         if (size > 132) size = 132;
`ifdef CR_HUF_COMP_STCL_UNPACK_CHK_EN
         if (pick == 3) size = int'($urandom_range(0, c));
`endif
         run_txn(mode[0], size, hc, int'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
